// File: rtl/io_ram_responder_if.sv
// ============================================================================
// Module   : io_ram_responder_if
// Purpose  : CPU io bus bundle (request, write data, read data, beat handshake)
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef MAX_BIT_POS
`define MAX_BIT_POS 31
`endif

interface io_ram_responder_if;
  logic [`MAX_BIT_POS:0] io_addr;
  logic                  io_read;
  logic                  io_write;
  logic                  burst;
  logic [2:0]            burst_size;
  logic                  read_ready;
  logic [`MAX_BIT_POS:0] io_wdata;
  logic [1:0]            io_byte_size;
  logic [`MAX_BIT_POS:0] io_rdata;
  logic                  io_ready;

  modport master (
    output io_addr, io_read, io_write, burst, burst_size, read_ready,
           io_wdata, io_byte_size,
    input  io_rdata, io_ready
  );

  modport slave (
    input  io_addr, io_read, io_write, burst, burst_size, read_ready,
           io_wdata, io_byte_size,
    output io_rdata, io_ready
  );
endinterface

`default_nettype wire

// File: rtl/io_ram_responder.sv
// ============================================================================
// Module   : io_ram_responder
// Purpose  : Word-addressed RAM responder on the CPU io bus with wait states,
//            bursts and read backpressure. Optional macro IO_RAM_BYTE_LANE_EN
//            enables byte-lane write masking.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef MAX_BIT_POS
`define MAX_BIT_POS 31
`endif

module io_ram_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  wire logic          clk,
  input  wire logic          rst,
  io_ram_responder_if.slave  bus,
  output logic               resp_busy
);

  localparam int               c_aw   = $clog2(DEPTH_WORDS);
  localparam logic [3:0]       c_wait = 4'(WAIT_CYCLES);
  localparam logic [c_aw-1:0]  c_one  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_BEAT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic [c_aw-1:0]       r_idx;
  logic [3:0]            r_beats;
  logic [3:0]            r_cnt;
  logic                  r_dir;
  logic                  r_ready;
  logic [`MAX_BIT_POS:0] r_rdata;
  logic [`MAX_BIT_POS:0] r_mem [DEPTH_WORDS];

  state_t                w_state_nxt;
  logic [c_aw-1:0]       w_idx_nxt;
  logic [3:0]            w_beats_nxt;
  logic [3:0]            w_cnt_nxt;
  logic                  w_dir_nxt;
  logic                  w_ready_nxt;
  logic                  w_rd_load;
  logic                  w_mem_we;
  logic                  w_accept;
  logic                  w_req;
  logic                  w_hit;
  logic [3:0]            w_beats_req;

  // Window is aligned to its size, so a hit is just a match on the upper bits.
  assign w_hit       = (bus.io_addr[`MAX_BIT_POS:c_aw+2] == BASE_ADDR[`MAX_BIT_POS:c_aw+2]);
  assign w_req       = bus.io_read | bus.io_write;
  assign w_beats_req = bus.burst ? ({1'b0, bus.burst_size} + 4'd1) : 4'd1;

  assign bus.io_ready = r_ready;
  assign bus.io_rdata = r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_beats   <= 4'd0;
      r_cnt     <= 4'd0;
      r_dir     <= 1'b0;
      r_ready   <= 1'b0;
      r_rdata   <= '0;
      resp_busy <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_beats   <= w_beats_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dir     <= w_dir_nxt;
      r_ready   <= w_ready_nxt;
      resp_busy <= (w_state_nxt != ST_IDLE);
      if (w_rd_load) begin
        r_rdata <= r_mem[w_idx_nxt];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_beats_nxt = r_beats;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_ready_nxt = 1'b0;
    w_rd_load   = 1'b0;
    w_mem_we    = 1'b0;
    w_accept    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_hit && w_req) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WAIT;
          w_idx_nxt   = bus.io_addr[c_aw+1:2];
          w_dir_nxt   = bus.io_write;
          w_beats_nxt = w_beats_req;
          w_cnt_nxt   = 4'd0;
        end
      end

      ST_WAIT: begin
        if (!w_req) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == c_wait) begin
          w_state_nxt = ST_BEAT;
          w_ready_nxt = 1'b1;
          w_rd_load   = !r_dir;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end

      ST_BEAT: begin
        if (!w_req) begin
          w_state_nxt = ST_IDLE;
        end else if (r_dir || bus.read_ready) begin
          // Writes complete every cycle; reads complete when the master accepts.
          w_mem_we    = r_dir;
          w_idx_nxt   = r_idx + c_one;
          w_beats_nxt = r_beats - 4'd1;
          if (r_beats == 4'd1) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_ready_nxt = 1'b1;
            w_rd_load   = !r_dir;
          end
        end else begin
          w_ready_nxt = 1'b1;
        end
      end

      ST_DONE: begin
        if (!w_req) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef IO_RAM_BYTE_LANE_EN
  logic [3:0] r_be;
  logic [3:0] w_be_req;

  // Misaligned half/word accesses fall back to a full-word write.
  always_comb begin
    w_be_req = 4'hF;
    if (bus.io_byte_size == 2'd0) begin
      w_be_req = 4'b0001 << bus.io_addr[1:0];
    end else if ((bus.io_byte_size == 2'd1) && !bus.io_addr[0]) begin
      w_be_req = 4'b0011 << bus.io_addr[1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_be <= 4'hF;
    end else if (w_accept) begin
      r_be <= w_be_req;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) begin
          r_mem[r_idx][8*b +: 8] <= bus.io_wdata[8*b +: 8];
        end
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{bus.io_byte_size, bus.io_addr[1:0], w_accept};

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_idx] <= bus.io_wdata;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_io_ram_responder.sv
// ============================================================================
// Module   : tb_io_ram_responder
// Purpose  : Randomized bench for io_ram_responder against a word-array model.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef MAX_BIT_POS
`define MAX_BIT_POS 31
`endif

module tb_io_ram_responder;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          WAITC = 2;

  logic clk = 1'b0;
  logic rst;
  logic resp_busy;

  io_ram_responder_if bus();

  io_ram_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .resp_busy (resp_busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] wbuf  [8];
  logic [31:0] last_rdata;
  logic [6:0]  rr_pat = 7'b1011001;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] lanes(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] m;
    m = 4'hF;
    if (sz == 2'd0) m = 4'b0001 << a;
    else if (sz == 2'd1 && !a[0]) m = 4'b0011 << a;
`ifndef IO_RAM_BYTE_LANE_EN
    m = 4'hF;
`endif
    return m;
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr - BASE) >> 2);
  endfunction

  task automatic start_req(input logic [31:0] addr, input int n, input logic wr, input logic [1:0] sz);
    bus.io_addr      = addr;
    bus.io_write     = wr;
    bus.io_read      = !wr;
    bus.burst        = (n > 1);
    bus.burst_size   = (n > 1) ? 3'(n - 1) : 3'($urandom_range(0, 7));
    bus.io_byte_size = sz;
  endtask

  // Wait for the first beat, checking the latency from the sampling edge.
  task automatic wait_first(input string tag);
    int lat;
    tick();
    check_val({tag, "_busy"}, {31'd0, resp_busy}, 32'd1);
    lat = 0;
    while (!bus.io_ready && lat < 40) begin
      tick();
      lat++;
    end
    check_val({tag, "_lat"}, lat, WAITC + 1);
  endtask

  task automatic finish_req(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_val({tag, "_done_rdy"}, {31'd0, bus.io_ready}, 32'd0);
      check_val({tag, "_done_busy"}, {31'd0, resp_busy}, 32'd1);
      tick();
    end
    bus.io_read  = 1'b0;
    bus.io_write = 1'b0;
    tick();
    check_val({tag, "_idle"}, {31'd0, resp_busy}, 32'd0);
  endtask

  task automatic do_write(input logic [31:0] addr, input int n, input logic [1:0] sz);
    int         idx;
    logic [3:0] m;
    idx = word_of(addr);
    m   = lanes(sz, addr[1:0]);
    start_req(addr, n, 1'b1, sz);
    bus.io_wdata = wbuf[0];
    wait_first("wr");
    for (int i = 0; i < n; i++) begin
      check_val("wr_rdy", {31'd0, bus.io_ready}, 32'd1);
      tick();
      if (i + 1 < n) bus.io_wdata = wbuf[i+1];
    end
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (m[b]) model[(idx + i) % DEPTH][8*b +: 8] = wbuf[i][8*b +: 8];
      end
    end
    finish_req("wr");
  endtask

  // mode 0: read_ready always 1; mode 1: fixed pattern; mode 2: random.
  task automatic do_read(input logic [31:0] addr, input int n, input int mode);
    int   idx, got, guard;
    logic rr;
    idx = word_of(addr);
    start_req(addr, n, 1'b0, 2'd2);
    bus.read_ready = 1'b1;
    wait_first("rd");
    got   = 0;
    guard = 0;
    while (got < n && guard < 200) begin
      check_val("rd_rdy", {31'd0, bus.io_ready}, 32'd1);
      check_val("rd_data", bus.io_rdata, model[(idx + got) % DEPTH]);
      last_rdata = bus.io_rdata;
      if (mode == 0)      rr = 1'b1;
      else if (mode == 1) rr = rr_pat[guard % 7];
      else                rr = 1'($urandom_range(0, 1));
      bus.read_ready = rr;
      tick();
      if (rr) got++;
      guard++;
    end
    check_val("rd_beats", got, n);
    bus.read_ready = 1'b1;
    finish_req("rd");
  endtask

  initial begin
    int          n;
    logic [31:0] a, saved;
    rst              = 1'b1;
    bus.io_addr      = '0;
    bus.io_read      = 1'b0;
    bus.io_write     = 1'b0;
    bus.burst        = 1'b0;
    bus.burst_size   = 3'd0;
    bus.read_ready   = 1'b1;
    bus.io_wdata     = '0;
    bus.io_byte_size = 2'd2;
    last_rdata       = '0;
    tick();
    tick();
    check_val("rst_rdy", {31'd0, bus.io_ready}, 32'd0);
    check_val("rst_rdata", bus.io_rdata, 32'd0);
    check_val("rst_busy", {31'd0, resp_busy}, 32'd0);
    rst = 1'b0;
    tick();

    // Fill the whole RAM so every model word is known.
    for (int blk = 0; blk < DEPTH / 8; blk++) begin
      for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
      do_write(BASE + 32'(blk * 32), 8, 2'd2);
    end

    wbuf[0] = 32'hDEADBEEF;
    do_write(BASE + 32'h10, 1, 2'd2);
    do_read(BASE + 32'h10, 1, 0);
    check_val("single_rd", last_rdata, 32'hDEADBEEF);

    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    do_write(BASE, 4, 2'd2);
    do_read(BASE, 4, 0);
    check_val("burst_last", last_rdata, 32'd4);
    do_read(BASE, 4, 1);

    // Wrap-around from the last word to word 0.
    wbuf[0] = 32'hCAFE0001;
    wbuf[1] = 32'hCAFE0002;
    do_write(BASE + 32'(DEPTH * 4 - 4), 2, 2'd2);
    do_read(BASE, 1, 0);
    check_val("wrap_w0", last_rdata, 32'hCAFE0002);
    do_read(BASE + 32'(DEPTH * 4 - 4), 2, 2);

    // Window misses on both sides and well outside.
    for (int k = 0; k < 3; k++) begin
      a = (k == 0) ? 32'h1000_0000 : (k == 1) ? BASE + 32'(DEPTH * 4) : BASE - 32'd4;
      start_req(a, 1, 1'b0, 2'd2);
      for (int c = 0; c < 20; c++) begin
        tick();
        check_val("miss_rdy", {31'd0, bus.io_ready}, 32'd0);
        check_val("miss_busy", {31'd0, resp_busy}, 32'd0);
      end
      bus.io_read = 1'b0;
      tick();
    end

    // Abort a read while waiting.
    start_req(BASE + 32'h8, 1, 1'b0, 2'd2);
    tick();
    tick();
    bus.io_read = 1'b0;
    tick();
    check_val("abort_wait_busy", {31'd0, resp_busy}, 32'd0);
    check_val("abort_wait_rdy", {31'd0, bus.io_ready}, 32'd0);

    // Abort a write during its beat: the word must keep its old value.
    a     = BASE + 32'h24;
    saved = model[word_of(a)];
    start_req(a, 1, 1'b1, 2'd2);
    bus.io_wdata = ~saved;
    wait_first("abort_wr");
    bus.io_write = 1'b0;
    tick();
    check_val("abort_beat_rdy", {31'd0, bus.io_ready}, 32'd0);
    check_val("abort_beat_busy", {31'd0, resp_busy}, 32'd0);
    do_read(a, 1, 0);
    check_val("abort_no_commit", last_rdata, saved);

    // Reset in the middle of a read burst.
    start_req(BASE, 8, 1'b0, 2'd2);
    wait_first("rst_mid");
    tick();
    rst = 1'b1;
    #1;
    check_val("rst_mid_rdy", {31'd0, bus.io_ready}, 32'd0);
    check_val("rst_mid_busy", {31'd0, resp_busy}, 32'd0);
    bus.io_read = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_val("rst_mid_idle", {31'd0, resp_busy}, 32'd0);

    // Sub-word write over a known word.
    wbuf[0] = 32'h11223344;
    do_write(BASE, 1, 2'd2);
    wbuf[0] = 32'hAAAAAAAA;
    do_write(BASE + 32'd1, 1, 2'd0);
    do_read(BASE, 1, 0);
`ifdef IO_RAM_BYTE_LANE_EN
    check_val("byte_lane", last_rdata, 32'h1122AA44);
`else
    check_val("byte_lane", last_rdata, 32'hAAAAAAAA);
`endif

    for (int t = 0; t < 40; t++) begin
      a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
      n = $urandom_range(1, 8);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
        do_write(a, n, 2'($urandom_range(0, 2)));
      end else begin
        do_read(a, n, 2);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/io_ram_responder.md
Name: io_ram_responder

Overview:
- Word-addressed RAM responder on the CPU io bus (io_addr/io_read/io_write/burst/burst_size/read_ready/io_wdata/io_byte_size/io_rdata/io_ready).
- Sits in the SoC as one responder on that bus. Serves single and burst reads and writes from the cpu_top bus master, with programmable wait states and read backpressure.
- Ignores addresses outside its window, so other responders can share the bus.

Parameters:
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two.
- BASE_ADDR, 32'h8000_0000: window base; must be aligned to DEPTH_WORDS*4.
- WAIT_CYCLES, 2: idle cycles between request accept and first beat; range 0..15.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- io_addr  in  `MAX_BIT_POS+1  byte address of the first beat
- io_read  in  1  read request, held by master for whole transaction
- io_write  in  1  write request, held by master for whole transaction
- burst  in  1  burst transaction
- burst_size  in  3  beats minus one, used when burst=1
- read_ready  in  1  master can accept read data this cycle
- io_wdata  in  `MAX_BIT_POS+1  write data for the current beat
- io_byte_size  in  2  0=byte, 1=half, 2=word
- io_rdata  out  `MAX_BIT_POS+1  read data, valid while io_ready=1 on reads
- io_ready  out  1  beat handshake
- resp_busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE; io_ready=0, io_rdata=0, resp_busy=0. RAM contents are not cleared.
- Hit condition: io_addr within [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4). On a miss, stay in IDLE and never drive io_ready.
- IDLE:
  - On a hit with io_read|io_write, latch the following, then go to WAIT:
    - word index = io_addr[log2(DEPTH_WORDS)+1:2]
    - dir = io_write. If io_read and io_write are both high, write wins.
    - beats = burst ? burst_size+1 : 1
    - byte_size
- WAIT: count WAIT_CYCLES cycles, then go to BEAT. With WAIT_CYCLES=0, go to BEAT on the next edge.
- BEAT, read:
  - io_ready=1 and io_rdata=mem[idx], registered.
  - The beat completes on the edge where read_ready=1.
  - While read_ready=0, hold io_ready and io_rdata stable.
- BEAT, write:
  - io_ready=1 for exactly one cycle.
  - mem[idx] is written from io_wdata at that edge.
  - The master must present the next beat's io_wdata in the cycle after it sees io_ready.
- Beat completion:
  - idx increments by 1, wrapping modulo DEPTH_WORDS.
  - Beats decrement. If beats remain, the next beat follows back-to-back with no additional wait states.
  - On the last beat, go to DONE.
- DONE: io_ready=0. Hold until io_read=0 and io_write=0, then go to IDLE. A held request is therefore never re-served.
- First io_ready is asserted WAIT_CYCLES+1 cycles after the request is sampled in IDLE.
- Abort: if io_read and io_write both drop during WAIT or BEAT, go to IDLE next edge with io_ready=0. A write beat not yet completed is not committed.
- Sub-word reads return the full aligned word; the master selects lanes.
- resp_busy is registered and mirrors state!=IDLE.

Optional Feature:
- Macro IO_RAM_BYTE_LANE_EN.
- Defined: writes use byte enables derived from io_byte_size and io_addr[1:0] of the first beat.
  - byte writes lane addr[1:0]; half writes lanes {addr[1],0} and {addr[1],1}; word writes all lanes.
  - A misaligned half or word is written as a full word.
- Undefined: every write stores all 32 bits regardless of io_byte_size.

Test Plan:
- WAIT_CYCLES=2: single word write 32'hDEADBEEF to 0x8000_0010, then read the same address with read_ready=1. Expect write io_ready at cycle 3, read io_rdata=32'hDEADBEEF with io_ready at cycle 3, then DONE until the request drops.
- Burst write burst=1, burst_size=3 at 0x8000_0000 with data 1,2,3,4, then burst read of 4 beats. Expect 4 back-to-back io_ready pulses and read data 1,2,3,4 in order.
- Burst read with read_ready toggling 1,0,0,1,1,0,1. Expect io_rdata held stable during read_ready=0, and exactly 4 beats delivered with no data skipped.
- Wrap-around: burst of 2 starting at the last word (BASE+DEPTH_WORDS*4-4). Expect the second beat to access word 0.
- Window miss: read at 0x1000_0000 held for 20 cycles. Expect io_ready=0 and resp_busy=0 throughout.
- Abort and reset:
  - Drop io_read in WAIT: expect IDLE the next cycle.
  - Assert rst mid-burst: expect io_ready=0 immediately.
  - With IO_RAM_BYTE_LANE_EN: byte write 8'hAA to 0x8000_0001 over word 0x11223344 reads back 0x1122AA44.
